// File: rtl/pwm_pkg.sv
// pwm_fade_ctrl shared definitions.
// Address maps and the per-step fade arithmetic.
package pwm_pkg;

  localparam int PWM_NCH = 8;

  localparam logic [4:0] HA_TGT   = 5'h00;
  localparam logic [4:0] HA_SHIFT = 5'h08;
  localparam logic [4:0] HA_STEP  = 5'h10;
  localparam logic [4:0] HA_DIVL  = 5'h18;
  localparam logic [4:0] HA_DIVH  = 5'h19;

  localparam logic [3:0] PA_THRESH = 4'h0;
  localparam logic [3:0] PA_SHIFT  = 4'h8;

  typedef enum logic [1:0] {
    HR_TGT   = 2'd0,
    HR_SHIFT = 2'd1,
    HR_STEP  = 2'd2,
    HR_CFG   = 2'd3
  } host_rgn_e;

  // One fade step toward tgt, clamped; stp==0 jumps straight to tgt.
  function automatic logic [7:0] fade_next(
    input logic [7:0] cur,
    input logic [7:0] tgt,
    input logic [7:0] stp
  );
    logic [8:0] up;
    logic [7:0] nxt;
    up  = {1'b0, cur} + {1'b0, stp};
    nxt = tgt;
    if (stp != 8'd0) begin
      if (cur < tgt)
        nxt = (up >= {1'b0, tgt}) ? tgt : up[7:0];
      else if (cur > tgt)
        nxt = (stp >= (cur - tgt)) ? tgt : (cur - stp);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// pwm_fade_ctrl bus bundle.
// Host write handshake plus the pwm core write port.
interface pwm_fade_ctrl_if;
  logic       host_valid;
  logic       host_ready;
  logic [4:0] host_addr;
  logic [7:0] host_data;
  logic [3:0] pwm_addr;
  logic [7:0] pwm_data;
  logic       pwm_we;

  modport master (
    output host_valid, host_addr, host_data,
    input  host_ready, pwm_addr, pwm_data, pwm_we
  );

  modport slave (
    input  host_valid, host_addr, host_data,
    output host_ready, pwm_addr, pwm_data, pwm_we
  );
endinterface

// File: rtl/pwm_rr_pick.sv
// Round-robin picker over 8 requests.
// First set bit at or above ptr, wrapping mod 8.
module pwm_rr_pick (
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  output logic       found_o,
  output logic [2:0] idx_o
);

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    for (int k = 7; k >= 0; k--) begin
      if (req_i[ptr_i + 3'(k)]) begin
        found_o = 1'b1;
        idx_o   = ptr_i + 3'(k);
      end
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer between host bus and pwm write port.
// Ramps thresholds on prescaler ticks, one write per clock.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int NCH     = PWM_NCH,
  parameter int PRESC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_fade_ctrl_if.slave  bus,
  output logic            settled,
  output logic            settle_irq
);

  logic                    rdy_q;
  logic [PRESC_W-1:0]      cnt_q, cnt_d;
  logic [PRESC_W-1:0]      div_q, div_d;
  logic [NCH-1:0][7:0]     cur_q, cur_d;
  logic [NCH-1:0][7:0]     tgt_q, tgt_d;
  logic [NCH-1:0][7:0]     step_q, step_d;
  logic [NCH-1:0]          pend_q, pend_d;
  logic [2:0]              rr_q;
  logic                    we_q;
  logic [3:0]              addr_q;
  logic [7:0]              data_q;
  logic                    settled_q, settled_d;
  logic                    irq_q;

  logic       acc;
  host_rgn_e  rgn;
  logic [2:0] ch_h;
  logic       wr_tgt, wr_shift, wr_step, wr_divl, wr_divh;
  logic       cnt_clr, tick;
  logic       pk_found, pk_go, pk_wr;
  logic [2:0] pk_idx;
  logic [7:0] pk_cur, pk_tgt, pk_nxt;

  assign acc      = bus.host_valid & rdy_q;
  assign rgn      = host_rgn_e'(bus.host_addr[4:3]);
  assign ch_h     = bus.host_addr[2:0];
  assign wr_tgt   = acc && (rgn == HR_TGT);
  assign wr_shift = acc && (rgn == HR_SHIFT);
  assign wr_step  = acc && (rgn == HR_STEP);
  assign wr_divl  = acc && (bus.host_addr == HA_DIVL);
  assign wr_divh  = acc && (bus.host_addr == HA_DIVH);

  // Divider update; shrinking below the count restarts it quietly.
  always_comb begin
    div_d = div_q;
    if (wr_divl) div_d[7:0] = bus.host_data;
    if (wr_divh) div_d[PRESC_W-1:8] = (PRESC_W-8)'(bus.host_data);
  end

  assign cnt_clr = (wr_divl | wr_divh) && (div_d < cnt_q);
  assign tick    = (cnt_q == div_q) && !cnt_clr;
  assign cnt_d   = (tick | cnt_clr) ? '0 : cnt_q + PRESC_W'(1);

  pwm_rr_pick u_pick (
    .req_i   (pend_q),
    .ptr_i   (rr_q),
    .found_o (pk_found),
    .idx_o   (pk_idx)
  );

  assign pk_go  = pk_found & ~wr_shift;
  assign pk_cur = cur_q[pk_idx];
  assign pk_tgt = tgt_q[pk_idx];
  assign pk_nxt = fade_next(pk_cur, pk_tgt, step_q[pk_idx]);
  assign pk_wr  = pk_go && (pk_cur != pk_tgt);

  // Channel state next values: pick, tick, then host register writes.
  always_comb begin
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    pend_d    = pend_q;
    settled_d = 1'b1;
    if (pk_wr) cur_d[pk_idx] = pk_nxt;
    if (pk_go) pend_d[pk_idx] = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (tick && (cur_d[i] != tgt_q[i])) pend_d[i] = 1'b1;
    end
    if (wr_tgt)  tgt_d[ch_h]  = bus.host_data;
    if (wr_step) step_d[ch_h] = bus.host_data;
    for (int i = 0; i < NCH; i++) begin
      if (cur_d[i] != tgt_d[i]) settled_d = 1'b0;
    end
    if (pend_d != '0) settled_d = 1'b0;
  end

  // Prescaler, channel registers, scheduler pointer and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
      div_q     <= '1;
      cur_q     <= '0;
      tgt_q     <= '0;
      step_q    <= {NCH{8'd1}};
      pend_q    <= '0;
      rr_q      <= 3'd0;
      settled_q <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      pend_q    <= pend_d;
      if (pk_go) rr_q <= pk_idx + 3'd1;
      settled_q <= settled_d;
      irq_q     <= settled_d & ~settled_q;
    end
  end

  // pwm port: passthrough first, else the fade pick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= 4'd0;
      data_q <= 8'd0;
    end else if (wr_shift) begin
      we_q   <= 1'b1;
      addr_q <= PA_SHIFT | {1'b0, ch_h};
      data_q <= bus.host_data;
    end else if (pk_wr) begin
      we_q   <= 1'b1;
      addr_q <= PA_THRESH | {1'b0, pk_idx};
      data_q <= pk_nxt;
    end else begin
      we_q   <= 1'b0;
    end
  end

  assign bus.host_ready = rdy_q;
  assign bus.pwm_we     = we_q;
  assign bus.pwm_addr   = addr_q;
  assign bus.pwm_data   = data_q;
  assign settled        = settled_q;
  assign settle_irq     = irq_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// pwm_fade_ctrl directed bench.
// Cycle-timed host writes; pwm writes logged with their cycle.
module tb_pwm_fade_ctrl;
  import pwm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic settled, settle_irq;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   irqs = 0;
  int   c0;
  logic [3:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];

  pwm_fade_ctrl_if bus();

  pwm_fade_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .settled    (settled),
    .settle_irq (settle_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pwm_we) begin
        wa.push_back(bus.pwm_addr);
        wd.push_back(bus.pwm_data);
        wc.push_back(cyc);
      end
      if (settle_irq) irqs++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) clk1();
  endtask

  task automatic clrq();
    wa.delete();
    wd.delete();
    wc.delete();
    irqs = 0;
  endtask

  task automatic hw(input logic [4:0] a, input logic [7:0] d);
    bus.host_valid = 1'b1;
    bus.host_addr  = a;
    bus.host_data  = d;
    clk1();
    bus.host_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.host_valid = 1'b0;
    run(2);
    rst_n = 1'b1;
    clrq();
    clk1();
  endtask

  task automatic chk_seq(input string tag, input int i,
                         input logic [3:0] a, input logic [7:0] d,
                         input int gap);
    if (i < wa.size()) begin
      chk({tag, "_addr"}, wa[i], a);
      chk({tag, "_data"}, wd[i], d);
      if (i > 0 && gap > 0)
        chk({tag, "_gap"}, wc[i] - wc[i-1], gap);
    end
  endtask

  initial begin
    int k;
    bus.host_valid = 1'b0;
    bus.host_addr  = 5'd0;
    bus.host_data  = 8'd0;

    // reset state and ramp
    #2 rst_n = 1'b0;
    run(2);
    chk("rst_ready", bus.host_ready, 0);
    chk("rst_we", bus.pwm_we, 0);
    chk("rst_addr", bus.pwm_addr, 0);
    chk("rst_data", bus.pwm_data, 0);
    chk("rst_settled", settled, 1);
    chk("rst_irq", settle_irq, 0);
    rst_n = 1'b1;
    clrq();
    clk1();
    chk("t1_ready", bus.host_ready, 1);
    chk("t1_we", bus.pwm_we, 0);
    chk("t1_settled", settled, 1);
    hw(HA_DIVH, 8'h00);
    hw(HA_DIVL, 8'h03);
    hw(HA_TGT + 5'd2, 8'h10);
    hw(HA_STEP + 5'd2, 8'h04);
    run(30);
    chk("t1_count", wa.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_seq("t1", i, 4'h2, 8'(4 * (i + 1)), 4);
    chk("t1_irq", irqs, 1);
    chk("t1_settled2", settled, 1);
    hw(HA_TGT + 5'd2, 8'h40);
    k = 0;
    while (!bus.pwm_we && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t1_midramp_we", bus.pwm_we, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_we", bus.pwm_we, 0);
    chk("t1_rst_settled", settled, 1);
    chk("t1_rst_data", bus.pwm_data, 0);

    // clamp, step 0 jump, no underflow
    do_reset();
    hw(HA_DIVH, 8'h00);
    hw(HA_DIVL, 8'h03);
    hw(HA_TGT + 5'd5, 8'h0A);
    hw(HA_STEP + 5'd5, 8'h04);
    run(30);
    chk("t2_count", wa.size(), 3);
    chk_seq("t2a", 0, 4'h5, 8'h04, 0);
    chk_seq("t2a", 1, 4'h5, 8'h08, 0);
    chk_seq("t2a", 2, 4'h5, 8'h0A, 0);
    clrq();
    hw(HA_STEP + 5'd5, 8'h00);
    hw(HA_TGT + 5'd5, 8'hF0);
    run(12);
    chk("t2_jump_count", wa.size(), 1);
    chk_seq("t2b", 0, 4'h5, 8'hF0, 0);
    clrq();
    hw(HA_STEP + 5'd5, 8'hFF);
    hw(HA_TGT + 5'd5, 8'h00);
    run(12);
    chk("t2_down_count", wa.size(), 1);
    chk_seq("t2c", 0, 4'h5, 8'h00, 0);
    chk("t2_settled", settled, 1);

    // round-robin
    do_reset();
    hw(HA_DIVH, 8'h00);
    for (int i = 0; i < 8; i++) hw(HA_TGT + 5'(i), 8'h01);
    run(2);
    hw(HA_DIVL, 8'h03);
    run(14);
    chk("t3_count", wa.size(), 8);
    for (int i = 0; i < 8; i++)
      chk_seq("t3", i, 4'(i), 8'h01, 1);
    clrq();
    hw(HA_DIVL, 8'hFF);
    hw(HA_TGT + 5'd2, 8'h02);
    run(5);
    hw(HA_DIVL, 8'h03);
    run(8);
    chk("t3_ch2_count", wa.size(), 1);
    chk_seq("t3b", 0, 4'h2, 8'h02, 0);
    clrq();
    hw(HA_DIVL, 8'hFF);
    hw(HA_TGT + 5'd1, 8'h02);
    hw(HA_TGT + 5'd5, 8'h02);
    run(5);
    hw(HA_DIVL, 8'h03);
    run(8);
    chk("t3_wrap_count", wa.size(), 2);
    chk_seq("t3c", 0, 4'h5, 8'h02, 0);
    chk_seq("t3c", 1, 4'h1, 8'h02, 1);

    // passthrough priority
    do_reset();
    hw(HA_DIVH, 8'h00);
    hw(HA_TGT + 5'd0, 8'h01);
    run(3);
    hw(HA_DIVL, 8'h02);
    run(3);
    hw(HA_SHIFT + 5'd3, 8'h07);
    chk("t4_pt_addr", bus.pwm_addr, 4'hB);
    chk("t4_pt_data", bus.pwm_data, 8'h07);
    run(4);
    chk("t4_count", wa.size(), 2);
    chk_seq("t4", 0, 4'hB, 8'h07, 0);
    chk_seq("t4", 1, 4'h0, 8'h01, 1);

    // retarget race
    do_reset();
    hw(HA_DIVH, 8'h00);
    hw(HA_TGT + 5'd4, 8'h05);
    run(3);
    hw(HA_DIVL, 8'h02);
    run(2);
    hw(HA_TGT + 5'd4, 8'h00);
    run(8);
    chk("t5_count", wa.size(), 0);
    chk("t5_settled", settled, 1);

    // prescaler div=0 and shrink below count
    do_reset();
    hw(HA_DIVH, 8'h00);
    hw(HA_TGT + 5'd3, 8'h03);
    hw(HA_DIVL, 8'h00);
    run(6);
    chk("t6_count", wa.size(), 3);
    for (int i = 0; i < 3; i++)
      chk_seq("t6", i, 4'h3, 8'(i + 1), 1);
    clrq();
    hw(HA_DIVL, 8'hFF);
    hw(HA_TGT + 5'd6, 8'h09);
    run(4);
    hw(HA_DIVL, 8'h02);
    c0 = cyc;
    run(8);
    chk("t6_any", wa.size() != 0, 1);
    if (wa.size() != 0) begin
      chk("t6_first_cyc", wc[0] - c0, 4);
      chk_seq("t6b", 0, 4'h6, 8'h01, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
